// File: rtl/mem_resp_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_resp_stage_pkg                                           |
// | Description : Shared load-op encodings and sizing constants for the MEM    |
// |               response stage and its load alignment helper.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_resp_stage_pkg;

  // Load type carried from EX; LD_NONE marks stores and non-memory ops.
  typedef enum logic [2:0] {
    LD_B    = 3'd0,
    LD_H    = 3'd1,
    LD_W    = 3'd2,
    LD_D    = 3'd3,
    LD_BU   = 3'd4,
    LD_HU   = 3'd5,
    LD_WU   = 3'd6,
    LD_NONE = 3'd7
  } load_op_e;

  localparam int C_PAYLOAD_W_DEFAULT     = 128;
  localparam int C_DATA_W_NARROW         = 32;
  localparam int C_DATA_W_WIDE           = 64;
  localparam int C_MAX_OUTSTANDING_LIMIT = 7;
  // Wide enough to count up to C_MAX_OUTSTANDING_LIMIT.
  localparam int C_CNT_W                 = 3;

  // Only 32- and 64-bit datapaths are supported.
  function automatic logic is_legal_data_w(input int w);
    return (w == C_DATA_W_NARROW) || (w == C_DATA_W_WIDE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_stage_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_resp_stage_load_align                                    |
// | Description : Combinational load lane select and sign/zero extension for   |
// |               32- or 64-bit data words.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_resp_stage_load_align
  import mem_resp_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]            rdata,
  input  logic [$clog2(DATA_W/8)-1:0]  addr_low,
  input  logic [2:0]                   load_op,
  output logic [DATA_W-1:0]            result
);

  localparam int AW = $clog2(DATA_W/8);

  logic [AW-1:0]     w_half_lane;
  logic [AW-1:0]     w_word_lane;
  logic [DATA_W-1:0] w_byte_sh;
  logic [DATA_W-1:0] w_half_sh;
  logic [DATA_W-1:0] w_word_sh;
  logic [63:0]       w_ext;

  // Half-word lane ignores addr bit 0 so a stray low bit can never pick a split lane.
  assign w_half_lane = {addr_low[AW-1:1], 1'b0};

  generate
    if (DATA_W == C_DATA_W_WIDE) begin : g_word_lane_64
      // Upper or lower 32-bit word of the doubleword.
      assign w_word_lane = {addr_low[AW-1], {(AW-1){1'b0}}};
    end else begin : g_word_lane_32
      // The whole bus is one word.
      assign w_word_lane = '0;
    end
  endgenerate

  assign w_byte_sh = rdata >> {addr_low, 3'b000};
  assign w_half_sh = rdata >> {w_half_lane, 3'b000};
  assign w_word_sh = rdata >> {w_word_lane, 3'b000};

  // Extend the selected lane in a 64-bit scratch value, then trim to the bus width.
  always_comb begin
    w_ext = 64'(rdata);
    case (load_op)
      LD_B:    w_ext = {{56{w_byte_sh[7]}},  w_byte_sh[7:0]};
      LD_H:    w_ext = {{48{w_half_sh[15]}}, w_half_sh[15:0]};
      LD_W:    w_ext = {{32{w_word_sh[31]}}, w_word_sh[31:0]};
      LD_BU:   w_ext = {56'd0, w_byte_sh[7:0]};
      LD_HU:   w_ext = {48'd0, w_half_sh[15:0]};
      LD_WU:   w_ext = {32'd0, w_word_sh[31:0]};
      default: w_ext = 64'(rdata);
    endcase
  end

  assign result = w_ext[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mem_resp_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_resp_stage                                               |
// | Description : MEM pipeline stage for a variable-latency data bus. Holds    |
// |               one instruction, tracks outstanding requests, buffers read   |
// |               data while WB stalls and drops responses of killed ops.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_resp_stage
  import mem_resp_stage_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int PAYLOAD_W       = C_PAYLOAD_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          es_to_ms_valid,
  output logic                          ms_allowin,
  input  logic                          es_mem_req,
  input  logic [2:0]                    es_load_op,
  input  logic [$clog2(DATA_W/8)-1:0]   es_addr_low,
  input  logic [DATA_W-1:0]             es_result,
  input  logic [PAYLOAD_W-1:0]          es_payload,
  input  logic                          req_issued,
  output logic                          req_allow,
  input  logic                          data_sram_data_ok,
  input  logic [DATA_W-1:0]             data_sram_rdata,
  input  logic                          flush,
  input  logic                          ws_allowin,
  output logic                          ms_to_ws_valid,
  output logic [DATA_W-1:0]             ms_result,
  output logic [PAYLOAD_W-1:0]          ms_payload,
  output logic                          ms_load_pending
);

  localparam int AW = $clog2(DATA_W/8);
  localparam logic [C_CNT_W-1:0] C_MAX  = C_CNT_W'(MAX_OUTSTANDING);
  localparam logic [C_CNT_W-1:0] C_ZERO = '0;
  localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);

  // Instruction held in MEM
  logic                 r_ms_valid;
  logic                 r_mem_req;
  logic [2:0]           r_load_op;
  logic [AW-1:0]        r_addr_low;
  logic [DATA_W-1:0]    r_es_result;
  logic [PAYLOAD_W-1:0] r_payload;

  // Read data parked while WB is stalled
  logic                 r_buf_valid;
  logic [DATA_W-1:0]    r_buf_data;

  // Request bookkeeping
  logic [C_CNT_W-1:0]   r_out_cnt;
  logic [C_CNT_W-1:0]   r_discard_cnt;

  logic                 w_discarding;
  logic                 w_resp_mine;
  logic                 w_ms_ready_go;
  logic                 w_leave;
  logic                 w_buf_capture;
  logic                 w_cnt_inc;
  logic                 w_cnt_dec;
  logic [C_CNT_W-1:0]   w_out_cnt_nxt;
  logic                 w_is_load;
  logic [DATA_W-1:0]    w_eff_data;
  logic [DATA_W-1:0]    w_aligned;

  // A response belongs to the MEM instruction only once all responses owed to
  // killed instructions have drained.
  assign w_discarding  = (r_discard_cnt != C_ZERO);
  assign w_resp_mine   = data_sram_data_ok && !w_discarding;

  assign w_ms_ready_go = !r_mem_req || r_buf_valid || w_resp_mine;
  assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go && !flush;
  assign ms_allowin    = !r_ms_valid || (w_ms_ready_go && ws_allowin);
  assign w_leave       = ms_to_ws_valid && ws_allowin;

  // Park the response only when it arrives and WB cannot take it this cycle.
  assign w_buf_capture = r_ms_valid && r_mem_req && !r_buf_valid && w_resp_mine
                         && !ws_allowin && !flush;

  // Saturating up/down count of issued-but-unreturned requests.
  assign w_cnt_inc     = req_issued && (r_out_cnt != C_MAX);
  assign w_cnt_dec     = data_sram_data_ok && (r_out_cnt != C_ZERO);
  assign w_out_cnt_nxt = r_out_cnt + (w_cnt_inc ? C_ONE : C_ZERO)
                                   - (w_cnt_dec ? C_ONE : C_ZERO);
  assign req_allow     = (r_out_cnt < C_MAX);

  assign w_is_load       = r_mem_req && (r_load_op != LD_NONE);
  assign ms_load_pending = r_ms_valid && w_is_load && !w_ms_ready_go;

  assign w_eff_data = r_buf_valid ? r_buf_data : data_sram_rdata;

  mem_resp_stage_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rdata    (w_eff_data),
    .addr_low (r_addr_low),
    .load_op  (r_load_op),
    .result   (w_aligned)
  );

  // Stores also wait for data_ok but forward the EX result.
  assign ms_result  = w_is_load ? w_aligned : r_es_result;
  assign ms_payload = r_payload;

  // Stage occupancy: a flush kills the held instruction and blocks a new one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid <= 1'b0;
    end else if (flush) begin
      r_ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      r_ms_valid <= es_to_ms_valid;
    end
  end

  // Instruction fields latched on an accepted handoff from EX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_req   <= 1'b0;
      r_load_op   <= LD_NONE;
      r_addr_low  <= '0;
      r_es_result <= '0;
      r_payload   <= '0;
    end else if (es_to_ms_valid && ms_allowin && !flush) begin
      r_mem_req   <= es_mem_req;
      r_load_op   <= es_load_op;
      r_addr_low  <= es_addr_low;
      r_es_result <= es_result;
      r_payload   <= es_payload;
    end
  end

  // Response buffer: filled on a stalled response, emptied on departure or flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
    end else if (flush || w_leave) begin
      r_buf_valid <= 1'b0;
    end else if (w_buf_capture) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= data_sram_rdata;
    end
  end

  // Outstanding-request counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_cnt <= '0;
    end else begin
      r_out_cnt <= w_out_cnt_nxt;
    end
  end

  // On flush every request still in flight after this cycle belongs to a killed
  // instruction; responses already consumed have left the count and are not
  // dropped twice.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_discard_cnt <= '0;
    end else if (flush) begin
      r_discard_cnt <= w_out_cnt_nxt;
    end else if (data_sram_data_ok && w_discarding) begin
      r_discard_cnt <= r_discard_cnt - C_ONE;
    end
  end

  // Bus protocol and parameter checks; the counter saturates when these fire.
  a_issue_overflow : assert property (@(posedge clk) disable iff (!resetn)
    !(req_issued && (r_out_cnt == C_MAX)));
  a_resp_underflow : assert property (@(posedge clk) disable iff (!resetn)
    !(data_sram_data_ok && (r_out_cnt == C_ZERO)));
  a_legal_params   : assert property (@(posedge clk)
    is_legal_data_w(DATA_W) && (MAX_OUTSTANDING >= 1)
    && (MAX_OUTSTANDING <= C_MAX_OUTSTANDING_LIMIT));

endmodule
`default_nettype wire

// File: tb/tb_mem_resp_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_resp_stage                                            |
// | Description : Randomised bench for mem_resp_stage (32- and 64-bit copies   |
// |               sharing one control stream) against a transaction model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_resp_stage;

  localparam int MAXO = 2;
  localparam int PW   = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          es_to_ms_valid, es_mem_req, req_issued, data_ok, flush, ws_allowin;
  logic [PW-1:0] es_payload;

  logic [2:0]    op32,  op64;
  logic [1:0]    addr32;
  logic [2:0]    addr64;
  logic [31:0]   esres32, rdata32, result32;
  logic [63:0]   esres64, rdata64, result64;
  logic          allow32, allow64, rallow32, rallow64, valid32, valid64, pend32, pend64;
  logic [PW-1:0] payload32, payload64;

  mem_resp_stage #(.DATA_W(32), .MAX_OUTSTANDING(MAXO), .PAYLOAD_W(PW)) dut32 (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(allow32),
    .es_mem_req(es_mem_req), .es_load_op(op32), .es_addr_low(addr32), .es_result(esres32),
    .es_payload(es_payload), .req_issued(req_issued), .req_allow(rallow32),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata32), .flush(flush),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(valid32), .ms_result(result32),
    .ms_payload(payload32), .ms_load_pending(pend32));

  mem_resp_stage #(.DATA_W(64), .MAX_OUTSTANDING(MAXO), .PAYLOAD_W(PW)) dut64 (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(allow64),
    .es_mem_req(es_mem_req), .es_load_op(op64), .es_addr_low(addr64), .es_result(esres64),
    .es_payload(es_payload), .req_issued(req_issued), .req_allow(rallow64),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata64), .flush(flush),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(valid64), .ms_result(result64),
    .ms_payload(payload64), .ms_load_pending(pend64));

  // ---------------- transaction model ----------------
  typedef struct {
    int            id;
    bit            mem;
    bit            issued;
    logic [2:0]    op32, op64;
    logic [1:0]    a32;
    logic [2:0]    a64;
    logic [31:0]   d32, r32, exp32;
    logic [63:0]   d64, r64, exp64;
    logic [PW-1:0] pl;
  } instr_t;

  typedef struct {
    int          id;       // -1 once the owning instruction was killed
    logic [31:0] d32;
    logic [63:0] d64;
    int          ready_at;
  } req_t;

  req_t   memq[$];
  instr_t ex, slot;
  bit     ex_valid, slot_valid, slot_have;
  int     next_id, cyc, dir_idx;
  int     n_checks, n_fail;

  // Directed instructions from the test plan go first.
  logic [2:0]  dir_op32 [3] = '{3'd0, 3'd5, 3'd2};
  logic [1:0]  dir_a32  [3] = '{2'd3, 2'd2, 2'd0};
  logic [31:0] dir_d32  [3] = '{32'h80AA_BBCC, 32'h9234_5678, 32'h1234_5678};
  logic [2:0]  dir_op64 [3] = '{3'd6, 3'd2, 3'd3};
  logic [2:0]  dir_a64  [3] = '{3'd4, 3'd4, 3'd0};

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] ext(input logic [63:0] v, input int bits, input bit sgn);
    logic [63:0] m;
    m = (64'd1 << bits) - 64'd1;
    v = v & m;
    if (sgn && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  // Load result from first principles: shift the addressed byte down, extend.
  function automatic logic [63:0] ref_load(input logic [2:0] op, input int addr, input logic [63:0] d);
    logic [63:0] v;
    v = d >> (8 * addr);
    case (op)
      3'd0: return ext(v, 8, 1'b1);
      3'd1: return ext(v, 16, 1'b1);
      3'd2: return ext(v, 32, 1'b1);
      3'd4: return ext(v, 8, 1'b0);
      3'd5: return ext(v, 16, 1'b0);
      3'd6: return ext(v, 32, 1'b0);
      default: return d;
    endcase
  endfunction

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      3'd3:       return 8;
      default:    return 1;
    endcase
  endfunction

  task automatic make_instr(output instr_t n);
    int k;
    logic [63:0] t;
    n.id = next_id; next_id++;
    n.issued = 1'b0;
    n.pl  = {$urandom, $urandom, $urandom, $urandom};
    n.r32 = $urandom;  n.r64 = {$urandom, $urandom};
    n.d32 = $urandom;  n.d64 = {$urandom, $urandom};
    if (dir_idx < 3) begin
      n.mem = 1'b1;
      n.op32 = dir_op32[dir_idx]; n.a32 = dir_a32[dir_idx]; n.d32 = dir_d32[dir_idx];
      n.op64 = dir_op64[dir_idx]; n.a64 = dir_a64[dir_idx];
      if (dir_idx < 2) n.d64 = 64'hF000_0001_0000_0002;
      dir_idx++;
    end else begin
      k = $urandom_range(0, 9);
      n.mem = (k < 8);
      if (k < 5) begin
        k = $urandom_range(0, 4);
        n.op32 = 3'((k < 3) ? k : k + 1);
        n.op64 = 3'($urandom_range(0, 6));
      end else if (k < 8) begin
        n.op32 = 3'd7; n.op64 = 3'd7;
      end else begin
        n.op32 = 3'($urandom_range(0, 7)); n.op64 = 3'($urandom_range(0, 7));
      end
      n.a32 = 2'($urandom_range(0, 3) & ~(op_size(n.op32) - 1));
      n.a64 = 3'($urandom_range(0, 7) & ~(op_size(n.op64) - 1));
    end
    t = ref_load(n.op32, int'(n.a32), {32'd0, n.d32});
    n.exp32 = (n.mem && n.op32 != 3'd7) ? t[31:0] : n.r32;
    n.exp64 = (n.mem && n.op64 != 3'd7) ? ref_load(n.op64, int'(n.a64), n.d64) : n.r64;
  endtask

  task automatic step();
    bit issue, offer, dok, hit, rdy, e_valid, e_allow, e_pend32, e_pend64, accept;
    req_t r;
    @(negedge clk);
    ws_allowin = ($urandom_range(0, 9) < 7);
    flush      = ($urandom_range(0, 39) == 0);
    if (!ex_valid && $urandom_range(0, 3) != 0) begin
      make_instr(ex);
      ex_valid = 1'b1;
    end
    issue = ex_valid && ex.mem && !ex.issued && (memq.size() < MAXO) && ($urandom_range(0, 1) == 1);
    offer = ex_valid && (!ex.mem || ex.issued || issue) && ($urandom_range(0, 4) != 0);
    // The bus only answers the MEM instruction's request or a killed one.
    dok = (memq.size() > 0) && (cyc >= memq[0].ready_at)
          && ((memq[0].id < 0) || (slot_valid && memq[0].id == slot.id))
          && ($urandom_range(0, 2) != 0);
    es_to_ms_valid = offer;
    es_mem_req = ex.mem;
    op32 = ex.op32; addr32 = ex.a32; esres32 = ex.r32;
    op64 = ex.op64; addr64 = ex.a64; esres64 = ex.r64;
    es_payload = ex.pl;
    req_issued = issue;
    data_ok = dok;
    rdata32 = dok ? memq[0].d32 : $urandom;
    rdata64 = dok ? memq[0].d64 : {$urandom, $urandom};
    #1;
    hit      = dok && (memq[0].id >= 0);
    rdy      = !slot.mem || slot_have || hit;
    e_valid  = slot_valid && rdy && !flush;
    e_allow  = !slot_valid || (rdy && ws_allowin);
    e_pend32 = slot_valid && slot.mem && (slot.op32 != 3'd7) && !rdy;
    e_pend64 = slot_valid && slot.mem && (slot.op64 != 3'd7) && !rdy;
    check("valid32",   PW'(valid32),  PW'(e_valid));
    check("valid64",   PW'(valid64),  PW'(e_valid));
    check("allowin32", PW'(allow32),  PW'(e_allow));
    check("allowin64", PW'(allow64),  PW'(e_allow));
    check("req_allow", PW'(rallow32), PW'(memq.size() < MAXO));
    check("req_allow64", PW'(rallow64), PW'(memq.size() < MAXO));
    check("pending32", PW'(pend32),   PW'(e_pend32));
    check("pending64", PW'(pend64),   PW'(e_pend64));
    if (e_valid) begin
      check("result32",  PW'(result32), PW'(slot.exp32));
      check("result64",  PW'(result64), PW'(slot.exp64));
      check("payload32", payload32, slot.pl);
      check("payload64", payload64, slot.pl);
    end
    // Advance the model across the clock edge.
    if (dok) begin
      void'(memq.pop_front());
      if (hit) slot_have = 1'b1;
    end
    if (e_valid && ws_allowin) slot_valid = 1'b0;
    if (issue) begin
      r.id = ex.id; r.d32 = ex.d32; r.d64 = ex.d64;
      r.ready_at = cyc + 1 + $urandom_range(0, 3);
      memq.push_back(r);
      ex.issued = 1'b1;
    end
    accept = offer && e_allow && !flush;
    if (accept) begin
      slot = ex; slot_valid = 1'b1; slot_have = 1'b0; ex_valid = 1'b0;
    end
    if (flush) begin
      slot_valid = 1'b0;
      ex_valid   = 1'b0;
      foreach (memq[i]) memq[i].id = -1;
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   PW'({valid32, valid64}),   PW'(2'b00));
    check({tag, "_allowin"}, PW'({allow32, allow64}),   PW'(2'b11));
    check({tag, "_reqallow"},PW'({rallow32, rallow64}), PW'(2'b11));
    check({tag, "_pending"}, PW'({pend32, pend64}),     PW'(2'b00));
  endtask

  task automatic quiet_inputs();
    es_to_ms_valid = 1'b0; req_issued = 1'b0; data_ok = 1'b0; flush = 1'b0;
    ws_allowin = 1'b1; es_mem_req = 1'b0;
    memq.delete(); slot_valid = 1'b0; slot_have = 1'b0; ex_valid = 1'b0;
    ex.mem = 1'b0; slot.mem = 1'b0;
  endtask

  initial begin
    int guard;
    n_checks = 0; n_fail = 0; next_id = 0; cyc = 0; dir_idx = 0;
    resetn = 1'b0;
    quiet_inputs();
    op32 = 3'd7; op64 = 3'd7; addr32 = '0; addr64 = '0;
    esres32 = '0; esres64 = '0; es_payload = '0; rdata32 = '0; rdata64 = '0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 2500; i++) step();

    // Look for a buffered response with a younger request in flight, then reset.
    guard = 0;
    while (!(slot_valid && slot_have && memq.size() == 1) && guard < 500) begin
      step();
      guard++;
    end
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    quiet_inputs();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_rst_allowin",  PW'({allow32, allow64}),   PW'(2'b11));
    check("post_rst_reqallow", PW'({rallow32, rallow64}), PW'(2'b11));

    for (int i = 0; i < 400; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
